// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio widths, transmitter FSM states and sample type
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int SLOT_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } tx_state_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - divides CLK into the I2S bit clock and flags each BCLK falling edge
module i2s_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       bclk_q, bclk_d;
  logic       tc;

  assign tc = (cnt_q == TC);

  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    bclk_d = bclk_q;
    if (tc) begin
      cnt_d  = 8'd0;
      bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 8'd0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  // High in the cycle whose clock edge drives BCLK low, so slot logic updates with the fall.
  assign fall_o = tc && bclk_q;
  assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S stereo DAC transmitter: sample buffering, slot FSM and serial shifter
module i2s_dac_tx #(
  parameter int CLK_DIV   = 8,
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int SLOT_BITS = audio_pkg::SLOT_BITS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] leftSampleIn,
  input  logic [SAMPLE_W-1:0] rightSampleIn,
  input  logic                sampleValid,
  output logic                sampleReq,
  output logic                underrun,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT
);

  localparam int             IDX_W    = $clog2(SLOT_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_BITS - 1);

  audio_pkg::tx_state_e state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SAMPLE_W-1:0]  hold_l_q, hold_r_q;
  logic [SAMPLE_W-1:0]  frame_l_q, frame_r_q;
  logic [SAMPLE_W-1:0]  shift_q;
  logic                 fresh_q;
  logic                 lrck_q, dat_q, req_q, ur_q;
  logic                 bclk, fall, load;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_i (CLK),
    .rst_i (RST),
    .bclk_o(bclk),
    .fall_o(fall)
  );

  assign load = fall && ((state_q == audio_pkg::IDLE) ||
                         ((state_q == audio_pkg::RIGHT) && (idx_q == LAST_IDX)));

  // A strobe in the load cycle still lands in holding and counts for the next frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      fresh_q  <= 1'b0;
    end else if (sampleValid) begin
      hold_l_q <= leftSampleIn;
      hold_r_q <= rightSampleIn;
      fresh_q  <= 1'b1;
    end else if (load) begin
      fresh_q  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= audio_pkg::IDLE;
      idx_q     <= '0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      shift_q   <= '0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      req_q     <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      req_q <= load;
      ur_q  <= load && !fresh_q;
      if (load) begin
        frame_l_q <= hold_l_q;
        frame_r_q <= hold_r_q;
      end
      if (fall) begin
        case (state_q)
          audio_pkg::IDLE: begin
            state_q <= audio_pkg::LEFT;
            idx_q   <= '0;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            shift_q <= hold_l_q;
          end
          audio_pkg::LEFT, audio_pkg::RIGHT: begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              dat_q <= 1'b0;
              if (state_q == audio_pkg::LEFT) begin
                state_q <= audio_pkg::RIGHT;
                lrck_q  <= 1'b1;
                shift_q <= frame_r_q;
              end else begin
                state_q <= audio_pkg::LEFT;
                lrck_q  <= 1'b0;
                shift_q <= hold_l_q;
              end
            end else begin
              // Once the sample is shifted out the register is all zeros, which pads the slot.
              idx_q   <= idx_q + 1'b1;
              dat_q   <= shift_q[SAMPLE_W-1];
              shift_q <= shift_q << 1;
            end
          end
          default: state_q <= audio_pkg::IDLE;
        endcase
      end
    end
  end

  assign sampleReq   = req_q;
  assign underrun    = ur_q;
  assign AUD_BCLK    = bclk;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx
module tb_i2s_dac_tx;
  import audio_pkg::*;

  logic    CLK = 1'b0;
  logic    RST = 1'b1;
  sample_t l_in = '0;
  sample_t r_in = '0;
  logic    sampleValid = 1'b0;
  logic    sampleReq, underrun, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

  int checks = 0;
  int fails  = 0;

  always #10 CLK = ~CLK;

  i2s_dac_tx dut (
    .CLK          (CLK),
    .RST          (RST),
    .leftSampleIn (l_in),
    .rightSampleIn(r_in),
    .sampleValid  (sampleValid),
    .sampleReq    (sampleReq),
    .underrun     (underrun),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT)
  );

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    l_in = a;
    r_in = b;
    sampleValid = 1'b1;
    @(negedge CLK);
    sampleValid = 1'b0;
  endtask

  task automatic wait_req(input string name, output logic ur, output int cyc);
    bit ok;
    ok = 0;
    ur = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge CLK);
      if (sampleReq === 1'b1) begin
        ok = 1;
        ur = underrun;
        cyc = i;
        break;
      end
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: sampleReq not seen, got timeout required pulse", name);
    end
  endtask

  task automatic capture_bits(output logic [15:0] l, output logic [15:0] r, output bit fmt_ok);
    logic prev;
    bit   seen;
    int   idx;
    l = '0;
    r = '0;
    fmt_ok = 1;
    for (int b = 0; b < 64; b++) begin
      seen = 0;
      prev = AUD_BCLK;
      for (int c = 0; c < 40; c++) begin
        @(negedge CLK);
        if (!prev && AUD_BCLK) begin
          seen = 1;
          break;
        end
        prev = AUD_BCLK;
      end
      if (!seen) fmt_ok = 0;
      idx = b % 32;
      if (AUD_DACLRCK !== (b >= 32)) fmt_ok = 0;
      if (idx >= 1 && idx <= 16) begin
        if (b < 32) l = {l[14:0], AUD_DACDAT};
        else        r = {r[14:0], AUD_DACDAT};
      end else if (AUD_DACDAT !== 1'b0) begin
        fmt_ok = 0;
      end
    end
  endtask

  task automatic measure(input bit sel, output int cyc);
    logic prev, cur;
    int   first;
    first = -1;
    cyc = -1;
    prev = sel ? AUD_DACLRCK : AUD_BCLK;
    for (int i = 0; i < 2500; i++) begin
      @(negedge CLK);
      cur = sel ? AUD_DACLRCK : AUD_BCLK;
      if (!prev && cur) begin
        if (first < 0) first = i;
        else begin
          cyc = i - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT} !== 3'b000) begin
      fails++;
      $display("FAIL reset_lines: got %b required 000", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT});
    end
    checks++;
    if ({sampleReq, underrun} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pulses: got %b required 00", {sampleReq, underrun});
    end
    RST = 1'b0;
  endtask

  task automatic test_clk_div();
    logic ur;
    int   cyc;
    wait_req("first_req", ur, cyc);
    checks++;
    if (cyc != 16) begin
      fails++;
      $display("FAIL first_req_delay: got %0d required 16", cyc);
    end
    checks++;
    if (ur !== 1'b1) begin
      fails++;
      $display("FAIL first_underrun: got %b required 1", ur);
    end
    measure(1'b0, cyc);
    checks++;
    if (cyc != 16) begin
      fails++;
      $display("FAIL bclk_period: got %0d required 16", cyc);
    end
    measure(1'b1, cyc);
    checks++;
    if (cyc != 1024) begin
      fails++;
      $display("FAIL lrck_period: got %0d required 1024", cyc);
    end
  endtask

  task automatic test_serial_format();
    logic        ur;
    int          cyc;
    logic [15:0] l, r;
    bit          fmt;
    wait_req("ser_sync", ur, cyc);
    send_pair(16'h8001, 16'h7FFE);
    wait_req("ser_load", ur, cyc);
    checks++;
    if (ur !== 1'b0) begin
      fails++;
      $display("FAIL ser_underrun: got %b required 0", ur);
    end
    capture_bits(l, r, fmt);
    checks++;
    if (l !== 16'h8001) begin
      fails++;
      $display("FAIL ser_left: got %h required 8001", l);
    end
    checks++;
    if (r !== 16'h7FFE) begin
      fails++;
      $display("FAIL ser_right: got %h required 7ffe", r);
    end
    checks++;
    if (!fmt) begin
      fails++;
      $display("FAIL ser_format: got bad framing/padding required clean slots");
    end
  endtask

  task automatic test_underrun();
    logic        ur;
    int          cyc;
    logic [15:0] l, r;
    bit          fmt;
    wait_req("ur_sync", ur, cyc);
    send_pair(16'h1234, 16'hABCD);
    wait_req("ur_load0", ur, cyc);
    checks++;
    if (ur !== 1'b0) begin
      fails++;
      $display("FAIL ur_fresh: got %b required 0", ur);
    end
    capture_bits(l, r, fmt);
    for (int f = 1; f <= 2; f++) begin
      wait_req("ur_repeat", ur, cyc);
      checks++;
      if (ur !== 1'b1) begin
        fails++;
        $display("FAIL ur_flag frame %0d: got %b required 1", f, ur);
      end
      capture_bits(l, r, fmt);
      checks++;
      if ({l, r} !== 32'h1234ABCD || !fmt) begin
        fails++;
        $display("FAIL ur_data frame %0d: got %h/%h fmt %0d required 1234/abcd fmt 1", f, l, r, fmt);
      end
    end
  endtask

  task automatic test_collision();
    logic        ur;
    int          cyc;
    logic [15:0] l, r;
    bit          fmt;
    wait_req("col_sync", ur, cyc);
    send_pair(16'hAAAA, 16'hBBBB);
    repeat (1022) @(negedge CLK);
    l_in = 16'h5555;
    r_in = 16'h5555;
    sampleValid = 1'b1;
    @(negedge CLK);
    sampleValid = 1'b0;
    checks++;
    if ({sampleReq, underrun} !== 2'b10) begin
      fails++;
      $display("FAIL col_load_cycle: got req/ur %b required 10", {sampleReq, underrun});
    end
    capture_bits(l, r, fmt);
    checks++;
    if ({l, r} !== 32'hAAAABBBB) begin
      fails++;
      $display("FAIL col_old_pair: got %h/%h required aaaa/bbbb", l, r);
    end
    wait_req("col_next", ur, cyc);
    checks++;
    if (ur !== 1'b0) begin
      fails++;
      $display("FAIL col_next_underrun: got %b required 0", ur);
    end
    capture_bits(l, r, fmt);
    checks++;
    if ({l, r} !== 32'h55555555) begin
      fails++;
      $display("FAIL col_new_pair: got %h/%h required 5555/5555", l, r);
    end
  endtask

  task automatic test_last_pair_wins();
    logic        ur;
    int          cyc;
    logic [15:0] l, r;
    bit          fmt;
    wait_req("lpw_sync", ur, cyc);
    send_pair(16'd1, 16'd1);
    repeat (50) @(negedge CLK);
    send_pair(16'd2, 16'd2);
    repeat (50) @(negedge CLK);
    send_pair(16'd3, 16'd3);
    wait_req("lpw_load", ur, cyc);
    capture_bits(l, r, fmt);
    checks++;
    if ({l, r} !== 32'h00030003 || ur !== 1'b0) begin
      fails++;
      $display("FAIL last_pair: got %h/%h ur %b required 0003/0003 ur 0", l, r, ur);
    end
  endtask

  task automatic test_midframe_reset();
    logic        ur;
    int          cyc;
    logic [15:0] l, r;
    bit          fmt;
    wait_req("mr_sync", ur, cyc);
    send_pair(16'h0F0F, 16'h00FF);
    wait_req("mr_load", ur, cyc);
    repeat (666) @(negedge CLK);
    checks++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT} !== 3'b111) begin
      fails++;
      $display("FAIL mr_before: got %b required 111", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT});
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sampleReq, underrun} !== 5'b00000) begin
      fails++;
      $display("FAIL mr_async: got %b required 00000",
               {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sampleReq, underrun});
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_req("mr_restart", ur, cyc);
    checks++;
    if (cyc != 16 || ur !== 1'b1) begin
      fails++;
      $display("FAIL mr_restart: got delay %0d ur %b required 16 ur 1", cyc, ur);
    end
    capture_bits(l, r, fmt);
    checks++;
    if ({l, r} !== 32'h0 || !fmt) begin
      fails++;
      $display("FAIL mr_zero_frame: got %h/%h fmt %0d required 0000/0000 fmt 1", l, r, fmt);
    end
  endtask

  initial begin
    test_reset();
    test_clk_div();
    test_serial_format();
    test_underrun();
    test_collision();
    test_last_pair_wins();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
